note_sequencer: RTL and testbench

//  Initiator side of the note-load handshake. Steps through a song stored in an

---
 rtl/note_sequencer.sv | 151 +++++++++++++++
 tb/tb_note_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note-load initiator: walks a song in a synchronous ROM and hands each
// {note, duration} to the note player, advancing on the player's note_done.
module note_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]       rom_data,
  output logic [NOTE_W-1:0]             note_out,
  output logic [DUR_W-1:0]              duration_out,
  output logic                          new_note,
  output logic                          song_done,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_PLAYING,
    S_DONE_HOLD
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_t                          state_q, state_d;
  logic [IDX_BITS-1:0]             idx_q, idx_d;
  logic [SONG_BITS-1:0]            song_reg_q, song_reg_d;
  logic [SONG_BITS+IDX_BITS-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]               note_q, note_d;
  logic [DUR_W-1:0]                dur_q, dur_d;
  logic                            new_note_q, new_note_d;
  logic                            song_done_q, song_done_d;
  logic                            busy_q, busy_d;

  logic [NOTE_W-1:0]               rom_note;
  logic [DUR_W-1:0]                rom_dur;
  logic                            song_change;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    song_reg_d  = song_reg_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    // A new song select while a song is in flight restarts from its first slot.
    song_change = (state_q inside {S_FETCH, S_LOAD, S_START, S_PLAYING}) &&
                  (song != song_reg_q);

    if (song_change) begin
      idx_d      = '0;
      song_reg_d = song;
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_d = '0;
          if (play) begin
            song_reg_d = song;
            state_d    = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (rom_dur == '0) begin
            song_done_d = 1'b1;
            state_d     = S_DONE_HOLD;
          end else begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
            state_d    = S_START;
          end
        end
        // The player loads on this cycle's edge; its note_done is stale here.
        S_START: state_d = S_PLAYING;
        S_PLAYING: begin
          if (note_done) begin
            if (idx_q == LAST_IDX) begin
              song_done_d = 1'b1;
              state_d     = S_DONE_HOLD;
            end else begin
              idx_d   = idx_q + IDX_BITS'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_DONE_HOLD: begin
          if (!play) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d     = state_d inside {S_FETCH, S_LOAD, S_START, S_PLAYING};
    rom_addr_d = {song_reg_d, idx_d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      song_reg_q  <= '0;
      rom_addr_q  <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_reg_q  <= song_reg_d;
      rom_addr_q  <= rom_addr_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign note_out     = note_q;
  assign duration_out = dur_q;
  assign new_note     = new_note_q;
  assign song_done    = song_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: ROM and player models, a note scoreboard, a
// table of whole-song runs and hand sequences for aborts, reset and pausing.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data = '0;
  logic [5:0]  note_out;
  logic [5:0]  duration_out;
  logic        new_note;
  logic        song_done;
  logic        busy;

  note_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .song         (song),
    .note_done    (note_done),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note_out     (note_out),
    .duration_out (duration_out),
    .new_note     (new_note),
    .song_done    (song_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM, {note, duration} per slot.
  logic [11:0] rom_mem [128];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Player: loads on new_note, counts down while play is high.
  logic [5:0] pcnt;
  logic       force_done = 1'b0;
  always @(posedge clk) begin
    if (reset)                     pcnt <= '0;
    else if (new_note)             pcnt <= duration_out;
    else if (play && pcnt != 6'd0) pcnt <= pcnt - 6'd1;
  end
  assign note_done = (pcnt == 6'd0) || (force_done && new_note);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and monitors
  logic [11:0] exp_q[$];
  logic [6:0]  addr_log[$];
  int          nn_cnt = 0;
  int          sd_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [6:0]  prev_addr = '0;

  always @(negedge clk) begin
    if (new_note) begin
      nn_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_new_note", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("note_out", note_out, e[11:6]);
        check("duration_out", duration_out, e[5:0]);
      end
    end
    if (song_done) sd_cnt++;
    if (busy && (!prev_busy || rom_addr != prev_addr)) addr_log.push_back(rom_addr);
    prev_busy = busy;
    prev_addr = rom_addr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_song_n(input logic [1:0] s, input int n);
    int pushed;
    logic [6:0] a;
    pushed = 0;
    for (int i = 0; i < 32 && pushed < n; i++) begin
      a = {s, 5'(i)};
      if (rom_mem[a][5:0] == 6'd0) break;
      exp_q.push_back(rom_mem[a]);
      pushed++;
    end
  endtask

  task automatic clear_counts();
    nn_cnt = 0;
    sd_cnt = 0;
    addr_log.delete();
    exp_q.delete();
  endtask

  task automatic stop_and_clear();
    play = 1'b0;
    tick();
    tick();
    clear_counts();
  endtask

  task automatic wait_done(input int max, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (sd_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_notes(input int n, input int max, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (nn_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  typedef struct {
    logic [1:0] song;
    int         exp_notes;
    int         exp_fetches;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int first_hits;
    logic [6:0] first_addr;

    vecs[0] = '{song: 2'd1, exp_notes: 2,  exp_fetches: 3};
    vecs[1] = '{song: 2'd2, exp_notes: 4,  exp_fetches: 5};
    vecs[2] = '{song: 2'd3, exp_notes: 32, exp_fetches: 32};
    vecs[3] = '{song: 2'd0, exp_notes: 8,  exp_fetches: 9};

    for (int i = 0; i < 128; i++) rom_mem[i] = '0;
    for (int i = 0; i < 8; i++)
      rom_mem[i] = {6'(6'h10 + i), (i == 5) ? 6'd4 : 6'(i % 2 + 1)};
    rom_mem[7'h20] = {6'h0A, 6'd3};
    rom_mem[7'h21] = {6'h0B, 6'd2};
    for (int i = 0; i < 4; i++) rom_mem[7'h40 + i] = {6'(6'h20 + i), 6'(i + 2)};
    for (int i = 0; i < 32; i++) rom_mem[7'h60 + i] = {1'b1, 5'(i), 6'(i % 3 + 1)};

    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_rom_addr", rom_addr, 7'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_new_note", new_note, 1'b0);
    check("rst_song_done", song_done, 1'b0);
    check("rst_note_out", note_out, 6'h00);
    check("rst_duration_out", duration_out, 6'h00);

    // Song 1 start latency and address walk
    clear_counts();
    push_song_n(2'd1, 32);
    song = 2'd1;
    play = 1'b1;
    tick();
    check("t1_fetch_addr", rom_addr, 7'h20);
    check("t1_fetch_busy", busy, 1'b1);
    check("t1_fetch_nn", new_note, 1'b0);
    tick();
    check("t1_load_nn", new_note, 1'b0);
    tick();
    check("t1_start_nn", new_note, 1'b1);
    wait_done(200, "t1_song_done_seen");
    repeat (15) tick();
    check("t1_notes", nn_cnt, 2);
    check("t1_done_pulses", sd_cnt, 1);
    check("t1_hold_busy", busy, 1'b0);
    check("t1_fetch_count", addr_log.size(), 3);
    for (int i = 0; i < addr_log.size() && i < 3; i++)
      check("t1_addr_walk", addr_log[i], 7'h20 + 7'(i));

    // Whole-song runs; note_done is also forced high during every START
    force_done = 1'b1;
    foreach (vecs[v]) begin
      stop_and_clear();
      push_song_n(vecs[v].song, 32);
      song = vecs[v].song;
      play = 1'b1;
      wait_done(2000, "run_song_done_seen");
      repeat (20) tick();
      first_addr = {vecs[v].song, 5'd0};
      first_hits = 0;
      foreach (addr_log[k]) if (addr_log[k] == first_addr) first_hits++;
      check("run_notes", nn_cnt, vecs[v].exp_notes);
      check("run_done_pulses", sd_cnt, 1);
      check("run_hold_busy", busy, 1'b0);
      check("run_queue_empty", exp_q.size(), 0);
      check("run_fetch_count", addr_log.size(), vecs[v].exp_fetches);
      check("run_first_addr_hits", first_hits, 1);
      if (addr_log.size() > 0)
        check("run_last_addr", addr_log[addr_log.size()-1],
              {vecs[v].song, 5'(vecs[v].exp_fetches - 1)});
    end
    force_done = 1'b0;

    // Song change 0 -> 2 while note 5 is playing
    stop_and_clear();
    push_song_n(2'd0, 6);
    song = 2'd0;
    play = 1'b1;
    wait_notes(6, 500, "t4_reach_note5");
    tick();
    push_song_n(2'd2, 32);
    song = 2'd2;
    tick();
    check("t4_abort_addr", rom_addr, 7'h40);
    check("t4_abort_busy", busy, 1'b1);
    check("t4_no_done", sd_cnt, 0);
    wait_done(500, "t4_song_done_seen");
    tick();
    check("t4_notes", nn_cnt, 10);
    check("t4_done_pulses", sd_cnt, 1);
    check("t4_queue_empty", exp_q.size(), 0);

    // Song change during LOAD suppresses new_note
    stop_and_clear();
    push_song_n(2'd2, 32);
    song = 2'd1;
    play = 1'b1;
    tick();
    tick();
    song = 2'd2;
    tick();
    check("tl_no_new_note", new_note, 1'b0);
    check("tl_abort_addr", rom_addr, 7'h40);
    wait_done(500, "tl_song_done_seen");
    tick();
    check("tl_notes", nn_cnt, 4);
    check("tl_queue_empty", exp_q.size(), 0);

    // Reset while in START, then restart with play still high
    stop_and_clear();
    push_song_n(2'd1, 1);
    song = 2'd1;
    play = 1'b1;
    tick();
    tick();
    tick();
    check("t5_start_nn", new_note, 1'b1);
    reset = 1'b1;
    tick();
    check("t5_rst_new_note", new_note, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_rom_addr", rom_addr, 7'h00);
    check("t5_rst_note_out", note_out, 6'h00);
    check("t5_rst_song_done", song_done, 1'b0);
    reset = 1'b0;
    clear_counts();
    push_song_n(2'd1, 32);
    tick();
    check("t5_restart_addr", rom_addr, 7'h20);
    wait_done(200, "t5_song_done_seen");
    tick();
    check("t5_notes", nn_cnt, 2);
    check("t5_queue_empty", exp_q.size(), 0);

    // play dropped in PLAYING for 10 cycles
    stop_and_clear();
    push_song_n(2'd2, 32);
    song = 2'd2;
    play = 1'b1;
    wait_notes(1, 50, "t6_first_note");
    tick();
    play = 1'b0;
    repeat (10) tick();
    check("t6_paused_notes", nn_cnt, 1);
    check("t6_paused_addr", rom_addr, 7'h40);
    check("t6_paused_busy", busy, 1'b1);
    play = 1'b1;
    wait_done(500, "t6_song_done_seen");
    tick();
    check("t6_notes", nn_cnt, 4);
    check("t6_done_pulses", sd_cnt, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    play = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
